// File: rtl/fifo_bundle_writer.sv
// Serializes fetch bundles of up to BUNDLE entries into the single-write-port
// instruction FIFO, one entry per cycle, lane 0 first, with flush recovery.
module fifo_bundle_writer #(
    parameter int WIDTH  = 32,
    parameter int BUNDLE = 3,
    localparam int CNT_BITS = $clog2(BUNDLE + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CNT_BITS-1:0]       in_count,
    input  logic [BUNDLE*WIDTH-1:0]   in_data,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wr_data,
    input  logic                      fifo_wr_valid,
    output logic [CNT_BITS-1:0]       pending,
    output logic                      busy
);

    // Handshakes: a bundle moves when in_valid && in_ready (count 0 is a no-op);
    // an entry moves when fifo_wr_en && fifo_wr_valid, and wr_en never waits on wr_valid.

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     bundle_q [BUNDLE];
    logic [CNT_BITS-1:0]  idx;
    logic [CNT_BITS-1:0]  cnt;

    logic                 last_write;
    logic                 accept;
    logic [CNT_BITS-1:0]  count_clamped;
    logic [WIDTH-1:0]     lane_data;

    // Illegal counts above BUNDLE are clamped rather than trusted.
    assign count_clamped = (in_count > CNT_BITS'(BUNDLE)) ? CNT_BITS'(BUNDLE) : in_count;

    assign fifo_wr_en = (state == DRAIN) && !flush && !reset;
    assign last_write = (state == DRAIN) && (idx == cnt - CNT_BITS'(1)) && fifo_wr_valid;
    assign in_ready   = !reset && !flush && ((state == IDLE) || last_write);
    assign accept     = in_valid && in_ready && (in_count != '0);

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < BUNDLE; i++) begin
            if (idx == CNT_BITS'(i)) begin
                lane_data = bundle_q[i];
            end
        end
    end

    assign fifo_wr_data = fifo_wr_en ? lane_data : '0;

    // idx <= cnt holds in every state, so this subtraction cannot wrap.
    assign pending = reset ? '0 : (cnt - idx);
    assign busy    = (pending != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            for (int i = 0; i < BUNDLE; i++) begin
                bundle_q[i] <= '0;
            end
        end else if (flush) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            // Overrides the final write's increment so bundles flow without a bubble.
            state <= DRAIN;
            idx   <= '0;
            cnt   <= count_clamped;
            for (int i = 0; i < BUNDLE; i++) begin
                bundle_q[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end else if ((state == DRAIN) && fifo_wr_valid) begin
            if (last_write) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                idx <= idx + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_bundle_writer.sv
// Scoreboard bench: a queue of unwritten entries models the writer; the monitor
// compares every FIFO offer and status output against it each cycle.
module tb_fifo_bundle_writer;

    localparam int WIDTH  = 32;
    localparam int BUNDLE = 3;
    localparam int CB     = $clog2(BUNDLE + 1);

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic [CB-1:0]           in_count = '0;
    logic [BUNDLE*WIDTH-1:0] in_data = '0;
    logic                    in_ready;
    logic                    flush = 1'b0;
    logic                    fifo_wr_en;
    logic [WIDTH-1:0]        fifo_wr_data;
    logic                    fifo_wr_valid;
    logic                    fifo_space = 1'b1;
    logic [CB-1:0]           pending;
    logic                    busy;

    // Expected model: entries accepted but not yet written, in FIFO order.
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_wr_en;
    logic             exp_ready;
    int               exp_pending;
    logic             active = 1'b0;
    int               errors = 0;
    int               checks = 0;

    fifo_bundle_writer #(.WIDTH(WIDTH), .BUNDLE(BUNDLE)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_count(in_count),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_valid(fifo_wr_valid),
        .pending(pending),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // The FIFO accepts whatever is offered while it has space.
    assign fifo_wr_valid = fifo_wr_en && fifo_space;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; expected outputs come from the queue model.
    task automatic cyc(input logic v, input int c, input logic [BUNDLE*WIDTH-1:0] d,
                       input logic f, input logic s, input logic r);
        int n;
        @(posedge clock);
        #1;
        in_valid   = v;
        in_count   = CB'(c);
        in_data    = d;
        flush      = f;
        fifo_space = s;
        reset      = r;
        n = exp_q.size();
        exp_wr_en   = !r && !f && (n > 0);
        exp_pending = r ? 0 : n;
        exp_ready   = !r && !f && ((n == 0) || ((n == 1) && s));
        if (r || f) exp_q.delete();
        if (!r && !f && v && exp_ready && (c != 0)) begin
            for (int i = 0; i < c; i++) exp_q.push_back(d[i*WIDTH +: WIDTH]);
        end
        active = 1'b1;
    endtask

    task automatic idle(input int k, input logic s);
        for (int i = 0; i < k; i++) cyc(1'b0, 0, '0, 1'b0, s, 1'b0);
    endtask

    always @(negedge clock) begin
        if (active) begin
            assert (!(in_valid && in_count > CB'(BUNDLE))) else $error("illegal in_count");
            chk("wr_en", {31'b0, fifo_wr_en}, {31'b0, exp_wr_en});
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            chk("pending", 32'(pending), 32'(exp_pending));
            chk("busy", {31'b0, busy}, {31'b0, exp_pending != 0});
            if (!fifo_wr_en) begin
                chk("idle_data", fifo_wr_data, '0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_wr_data, 32'hdead_beef);
            end else begin
                chk("wr_data", fifo_wr_data, exp_q[0]);
                if (fifo_wr_valid) void'(exp_q.pop_front());
            end
        end
    end

    localparam logic [WIDTH-1:0] A = 32'haaaa_0001;
    localparam logic [WIDTH-1:0] B = 32'hbbbb_0002;
    localparam logic [WIDTH-1:0] C = 32'hcccc_0003;

    initial begin
        logic [BUNDLE*WIDTH-1:0] rd;
        // Reset state.
        for (int i = 0; i < 3; i++) cyc(1'b1, 3, {C, B, A}, 1'b0, 1'b1, 1'b1);
        // Single bundle, FIFO never full.
        cyc(1'b1, 3, {C, B, A}, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b1);
        // Back-to-back {A,B} then {C}.
        cyc(1'b1, 2, {C, B, A}, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1, {A, A, C}, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1, {A, A, C}, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        // FIFO full stall on lane 0.
        cyc(1'b1, 3, {C, B, A}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1, {A, B, C}, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b1);
        // Flush with two entries left.
        cyc(1'b1, 3, {C, B, A}, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        cyc(1'b1, 2, {C, B, A}, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        // Zero-count handshake, then reset mid-drain.
        cyc(1'b1, 0, {C, B, A}, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 3, {C, B, A}, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom(), $urandom(), $urandom()};
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, BUNDLE), rd,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 63) == 0);
        end
        idle(BUNDLE + 2, 1'b1);
        @(negedge clock);
        #1;
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_bundle_writer.md
Name: fifo_bundle_writer

Overview:
- Producer-side serializer for the single-write-port instruction FIFO.
- Accepts a bundle of up to BUNDLE entries per handshake from fetch and registers it.
- Pushes the entries into the FIFO one per cycle, lane 0 first, through the FIFO's wr_en / wr_data / wr_valid interface.
- Provides back-pressure to fetch, plus a flush path for branch mispredict recovery.

Parameters:
- WIDTH, 32, bits per FIFO entry.
- BUNDLE, 3, maximum entries per accepted bundle; equals the FIFO's MAX_CNT.
- CNT_BITS, $clog2(BUNDLE+1), width of count fields (localparam).

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  fetch presents a bundle.
- in_count  input  CNT_BITS  number of valid lanes, 0..BUNDLE; lanes are packed from lane 0.
- in_data  input  BUNDLE*WIDTH  lane i = in_data[i*WIDTH +: WIDTH].
- in_ready  output  1  writer will accept a bundle this cycle.
- flush  input  1  discard all unwritten entries.
- fifo_wr_en  output  1  write request to the FIFO.
- fifo_wr_data  output  WIDTH  entry being offered.
- fifo_wr_valid  input  1  FIFO accepted the write this cycle.
- pending  output  CNT_BITS  entries held and not yet written.
- busy  output  1  pending != 0.

Behaviour:
- State:
  - bundle register: BUNDLE x WIDTH.
  - idx: CNT_BITS, next lane to write.
  - cnt: CNT_BITS, lanes in the held bundle.
  - States: IDLE (cnt==0) and DRAIN (idx<cnt).
- Reset:
  - idx=0, cnt=0, state IDLE.
  - Outputs during and after reset: fifo_wr_en=0, pending=0, busy=0.
  - in_ready=0 while reset is high.
  - fifo_wr_data is don't-care while fifo_wr_en=0; drive 0.
- Reset mid-DRAIN drops the held bundle; no further writes are issued.
- Write side:
  - fifo_wr_en = (state==DRAIN) && !flush.
  - fifo_wr_data = bundle[idx], combinational from registers.
  - fifo_wr_en depends only on registered state, flush and reset. It must not depend on fifo_wr_valid, because the FIFO derives wr_valid from wr_en.
  - When fifo_wr_valid: idx <= idx+1.
  - The last lane written (idx==cnt-1 && fifo_wr_valid) returns the block to IDLE unless a new bundle is accepted in the same cycle.
  - When fifo_wr_valid=0 (FIFO full): hold idx, keep fifo_wr_en high, keep fifo_wr_data stable.
- Accept side:
  - in_ready = !reset && !flush && (state==IDLE || (idx==cnt-1 && fifo_wr_valid)).
  - Accept = in_valid && in_ready && in_count!=0.
  - On accept: bundle <= in_data, cnt <= in_count, idx <= 0.
  - Accept overrides the idx increment of the final write in the same cycle, which gives back-to-back bundles with no bubble.
  - in_valid with in_count==0 is a no-op handshake: in_ready is still reported and state is unchanged.
  - in_count>BUNDLE is illegal. The bench asserts on it; RTL clamps to BUNDLE.
- Latency:
  - Lane 0 of an accepted bundle appears on fifo_wr_en the cycle after acceptance.
  - Throughput is 1 entry/cycle while the FIFO is not full.
  - A bundle of n lanes needs at least n cycles.
- Flush:
  - Highest priority after reset.
  - In the flush cycle: fifo_wr_en=0 and in_ready=0.
  - Next cycle: idx=0, cnt=0, IDLE.
  - A write already counted in an earlier cycle is not retracted.
- pending = cnt - idx, an unsigned CNT_BITS subtraction that never underflows, since idx<=cnt always holds.
- Ordering: entries reach the FIFO in lane order, and bundles in acceptance order.
- No entry is duplicated or skipped under stalls.

Test Plan:
- Reset, then bundle {A,B,C} with count=3 accepted at cycle t, with fifo_wr_valid always 1 -> fifo_wr_en high at t+1..t+3 with data A,B,C; in_ready high at t+3; pending 3,2,1, then 0.
- Back-to-back bundles {A,B} then {C}, with in_valid held and FIFO never full -> data A,B,C on consecutive cycles with no bubble; second bundle accepted in B's write cycle.
- FIFO full stall: bundle {A,B,C}, fifo_wr_valid=0 for 4 cycles after A's first offer -> A held stable with fifo_wr_en=1 throughout; then A,B,C written once each; in_ready=0 during the stall.
- Flush while pending=2 after A is written -> fifo_wr_en=0 in the flush cycle; pending=0 and in_ready=1 the next cycle; B and C are never written.
- in_valid with count=0 while IDLE -> no state change and fifo_wr_en stays 0; then reset asserted mid-DRAIN -> fifo_wr_en=0 and busy=0 the cycle after.
